alarm_timer_unit: RTL and testbench
===================================

// Module: alarm_timer_unit
// PURPOSE
//   Timing front-end for the alarm-clock control unit. Derives a 1 s tick from Clk.
//   Detects the alarm-time match and raises AA.
//   Runs the ring-timeout counter, enabled by EN_STOP, and reports expiry on C0.
//   Runs the snooze counter, enabled by EN_SNZ, and reports expiry on CS0.
//   Sits directly upstream of the control unit, feeding AA/C0/CS0 and consuming its EN_* outputs.
// PARAMETERS
//   TICK_DIV    100  Clk cycles per 1 s tick (>=2)
//   RING_SEC    60   ring duration in ticks before C0 asserts (>=1)
//   SNOOZE_SEC  300  snooze duration in ticks before CS0 asserts (>=1)
//   CNT_W       16   width of prescaler and both second counters; all params < 2**CNT_W
// PORTS
//   Clk         in   1  single clock, rising edge
//   Reset       in   1  synchronous, active-high
//   Cur_Hour    in   5  current hour, binary 0-23
//   Cur_Min     in   6  current minute, binary 0-59
//   Cur_Sec     in   6  current second, binary 0-59
//   Alarm_Hour  in   5  alarm hour, binary 0-23
//   Alarm_Min   in   6  alarm minute, binary 0-59
//   Alarm_On    in   1  alarm armed
//   EN_STOP     in   1  ring state active (from control unit)
//   EN_SNZ      in   1  snooze state active (from control unit)
//   Tick        out  1  one-cycle pulse every TICK_DIV cycles
//   AA          out  1  one-cycle alarm-match pulse
//   C0          out  1  ring timeout expired
//   CS0         out  1  snooze period expired
// BEHAVIOUR
//   Reset (sync): pre_cnt=0, ring_cnt=RING_SEC, snz_cnt=SNOOZE_SEC, match_q=1.
//     Tick, AA, C0 and CS0 are 0 in the cycle after the Reset edge and while Reset is held.
//   Prescaler: free-running, pre_cnt counts 0..TICK_DIV-1, then wraps to 0.
//     Tick is registered; it is 1 for exactly the cycle after pre_cnt==TICK_DIV-1.
//     The first Tick comes TICK_DIV cycles after Reset is released.
//   Match: match = Alarm_On & Cur_Hour==Alarm_Hour & Cur_Min==Alarm_Min & Cur_Sec==0.
//     match_q <= match every cycle. AA is registered: AA <= match & ~match_q (rising edge only).
//     A match held for many cycles gives one AA. match_q resets to 1, so no AA fires if
//     match is already true when Reset is released. Ranges are not checked; out-of-range
//     inputs are compared as-is.
//   Ring counter:
//     EN_STOP=0: ring_cnt <= RING_SEC (reload every cycle).
//     EN_STOP=1 & Tick & ring_cnt!=0: ring_cnt <= ring_cnt-1. The counter saturates at 0.
//     C0 = EN_STOP & (ring_cnt==0), decoded from registers with no added delay.
//     C0 rises in the cycle after the RING_SEC-th Tick seen with EN_STOP=1.
//     C0 holds while EN_STOP=1 and falls the cycle after EN_STOP falls.
//   Snooze counter: identical rules using EN_SNZ, snz_cnt, SNOOZE_SEC and CS0.
//   Dropping an enable mid-count discards progress; re-enabling starts a full period.
//   EN_STOP and EN_SNZ high together: the two counters run independently.
//   A Tick in the same cycle an enable rises counts toward the new period.
//   Reset mid-count overrides everything: counters reload, and a held enable restarts counting
//     after release.
// TESTING (TICK_DIV=4, RING_SEC=2, SNOOZE_SEC=3)
//   Reset 3 cycles with EN_* held 1 -> Tick/AA/C0/CS0=0; first Tick 4 cycles after release.
//   Alarm 07:30 on; Cur 07:29:59 -> 07:30:00 held 10 cycles -> AA=1 exactly 1 cycle;
//     repeat with Alarm_On=0 -> AA stays 0.
//   EN_STOP=1 -> C0=1 the cycle after the 2nd Tick, held until EN_STOP=0, then 0 next cycle.
//   EN_SNZ=1 for 1 Tick, drop 2 cycles, re-raise -> CS0 only after 3 further Ticks.
//   EN_SNZ held; Reset pulsed after 2 Ticks -> CS0 stays 0; CS0 rises 3 Ticks after release.
//   Cur==Alarm at second 0 during Reset, then Reset released -> AA never asserts.

Source files
------------

// File: rtl/alarm_timer_unit.sv
// Timing front-end for the alarm-clock control unit: 1 s prescaler, alarm-match
// edge detector, and the ring-timeout and snooze second counters.
module alarm_timer_unit #(
    parameter int unsigned TICK_DIV   = 100,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [4:0] Cur_Hour,
    input  logic [5:0] Cur_Min,
    input  logic [5:0] Cur_Sec,
    input  logic [4:0] Alarm_Hour,
    input  logic [5:0] Alarm_Min,
    input  logic       Alarm_On,
    input  logic       EN_STOP,
    input  logic       EN_SNZ,
    output logic       Tick,
    output logic       AA,
    output logic       C0,
    output logic       CS0
);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] RING_LOAD = CNT_W'(RING_SEC);
    localparam logic [CNT_W-1:0] SNZ_LOAD  = CNT_W'(SNOOZE_SEC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] pre_cnt;
    logic [CNT_W-1:0] ring_cnt;
    logic [CNT_W-1:0] snz_cnt;
    logic             match;
    logic             match_q;

    // Alarm match condition; out-of-range time values are compared as-is.
    always_comb begin
        match = Alarm_On && (Cur_Hour == Alarm_Hour) && (Cur_Min == Alarm_Min)
                && (Cur_Sec == 6'd0);
    end

    // Free-running prescaler; Tick is registered one cycle after the last count.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pre_cnt <= '0;
            Tick    <= 1'b0;
        end else begin
            if (pre_cnt == PRE_LAST) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + CNT_ONE;
            end
            Tick <= (pre_cnt == PRE_LAST);
        end
    end

    // Rising-edge detect on match; match_q resets high so a match already
    // present at reset release does not fire AA.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            match_q <= 1'b1;
            AA      <= 1'b0;
        end else begin
            match_q <= match;
            AA      <= match && !match_q;
        end
    end

    // Ring-timeout counter: reloads while disabled, saturates at zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ring_cnt <= RING_LOAD;
        end else if (!EN_STOP) begin
            ring_cnt <= RING_LOAD;
        end else if (Tick && (ring_cnt != '0)) begin
            ring_cnt <= ring_cnt - CNT_ONE;
        end
    end

    // Snooze counter: same rules as the ring counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            snz_cnt <= SNZ_LOAD;
        end else if (!EN_SNZ) begin
            snz_cnt <= SNZ_LOAD;
        end else if (Tick && (snz_cnt != '0)) begin
            snz_cnt <= snz_cnt - CNT_ONE;
        end
    end

    // Expiry flags decoded straight from the counters, gated by their enables.
    always_comb begin
        C0  = EN_STOP && (ring_cnt == '0);
        CS0 = EN_SNZ && (snz_cnt == '0);
    end

endmodule

// File: tb/tb_alarm_timer_unit.sv
// Directed bench for alarm_timer_unit with TICK_DIV=4, RING_SEC=2, SNOOZE_SEC=3.
module tb_alarm_timer_unit;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [4:0] Cur_Hour;
    logic [5:0] Cur_Min;
    logic [5:0] Cur_Sec;
    logic [4:0] Alarm_Hour;
    logic [5:0] Alarm_Min;
    logic       Alarm_On;
    logic       EN_STOP;
    logic       EN_SNZ;
    logic       Tick;
    logic       AA;
    logic       C0;
    logic       CS0;

    int n_checks = 0;
    int n_fail   = 0;
    // Edges since the last edge that saw Reset high.
    int cyc      = 0;

    alarm_timer_unit #(
        .TICK_DIV  (4),
        .RING_SEC  (2),
        .SNOOZE_SEC(3),
        .CNT_W     (16)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Cur_Hour  (Cur_Hour),
        .Cur_Min   (Cur_Min),
        .Cur_Sec   (Cur_Sec),
        .Alarm_Hour(Alarm_Hour),
        .Alarm_Min (Alarm_Min),
        .Alarm_On  (Alarm_On),
        .EN_STOP   (EN_STOP),
        .EN_SNZ    (EN_SNZ),
        .Tick      (Tick),
        .AA        (AA),
        .C0        (C0),
        .CS0       (CS0)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %b expected %b at cyc %0d", tag, obs, exp, cyc);
            $error("check %s", tag);
        end
    endtask

    // Advance one clock, sample 1 ns after the edge and check Tick against the
    // prescaler model: a tick follows every 4th edge after reset release.
    task automatic step();
        @(posedge Clk);
        #1;
        if (Reset) cyc = 0;
        else cyc++;
        check("tick", Tick, (!Reset && cyc > 0 && (cyc % 4) == 0));
    endtask

    task automatic set_cur(input int h, input int m, input int s);
        Cur_Hour = 5'(h);
        Cur_Min  = 6'(m);
        Cur_Sec  = 6'(s);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset      = 1'b1;
        EN_STOP    = 1'b1;
        EN_SNZ     = 1'b1;
        Alarm_On   = 1'b0;
        Alarm_Hour = 5'd7;
        Alarm_Min  = 6'd30;
        set_cur(7, 29, 59);

        // Reset held with enables high: all outputs low.
        repeat (3) begin
            step();
            check("rst_aa", AA, 1'b0);
            check("rst_c0", C0, 1'b0);
            check("rst_cs0", CS0, 1'b0);
        end

        // Release; first Tick after the 4th edge (checked inside step).
        Reset   = 1'b0;
        EN_STOP = 1'b0;
        EN_SNZ  = 1'b0;
        repeat (5) step();

        // Alarm 07:30 armed, time steps 07:29:59 -> 07:30:00 held 10 cycles.
        Alarm_On = 1'b1;
        step();
        check("aa_pre", AA, 1'b0);
        set_cur(7, 30, 0);
        step();
        check("aa_rise", AA, 1'b1);
        repeat (9) begin
            step();
            check("aa_hold", AA, 1'b0);
        end
        set_cur(7, 29, 59);
        repeat (2) begin
            step();
            check("aa_leave", AA, 1'b0);
        end

        // Same match with alarm disarmed.
        Alarm_On = 1'b0;
        set_cur(7, 30, 0);
        repeat (3) begin
            step();
            check("aa_off", AA, 1'b0);
        end
        set_cur(7, 29, 59);

        // Ring: enabled at cyc 21, ticks after edges 24 and 28, C0 after edge 29.
        EN_STOP = 1'b1;
        while (cyc < 28) begin
            step();
            check("c0_count", C0, 1'b0);
        end
        step();
        check("c0_rise", C0, 1'b1);
        repeat (4) begin
            step();
            check("c0_hold", C0, 1'b1);
        end
        EN_STOP = 1'b0;
        step();
        check("c0_fall", C0, 1'b0);

        // Snooze: one tick counted, dropped 2 cycles, then a full 3-tick period.
        EN_SNZ = 1'b1;
        while (cyc < 37) begin
            step();
            check("cs0_first", CS0, 1'b0);
        end
        EN_SNZ = 1'b0;
        repeat (2) begin
            step();
            check("cs0_drop", CS0, 1'b0);
        end
        EN_SNZ = 1'b1;
        while (cyc < 48) begin
            step();
            check("cs0_restart", CS0, 1'b0);
        end
        step();
        check("cs0_rise", CS0, 1'b1);
        EN_SNZ = 1'b0;
        step();
        check("cs0_fall", CS0, 1'b0);

        // Snooze held, reset after two ticks; then both counters run together.
        EN_SNZ = 1'b1;
        while (cyc < 57) begin
            step();
            check("cs0_pre_rst", CS0, 1'b0);
        end
        Reset = 1'b1;
        step();
        check("cs0_in_rst", CS0, 1'b0);
        check("c0_in_rst", C0, 1'b0);
        Reset   = 1'b0;
        EN_STOP = 1'b1;
        while (cyc < 13) begin
            step();
            check("c0_both", C0, (cyc >= 9));
            check("cs0_post_rst", CS0, (cyc >= 13));
        end
        EN_STOP = 1'b0;
        EN_SNZ  = 1'b0;
        step();
        check("c0_off", C0, 1'b0);
        check("cs0_off", CS0, 1'b0);

        // Match already present across reset release: no AA.
        Alarm_On = 1'b1;
        set_cur(7, 30, 0);
        Reset = 1'b1;
        repeat (2) begin
            step();
            check("aa_in_rst", AA, 1'b0);
        end
        Reset = 1'b0;
        repeat (5) begin
            step();
            check("aa_after_rst", AA, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
